// File: rtl/img_io_rx_controller_pkg.sv
// Shared image-path types: pixel/address widths, receive FSM states and the
// largest supported frame dimension.
package img_pkg;

  typedef logic [7:0] pixel_t;
  typedef logic [7:0] img_addr_t;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rx_state_t;

  localparam int IMG_MAX_DIM = 255;

endpackage

// File: rtl/img_io_rx_controller_if.sv
// Image SRAM port bundle; the master drives address, data and strobes, the
// memory returns read data on dout.
interface img_sram_intf;
  import img_pkg::*;

  pixel_t    din;
  img_addr_t row;
  img_addr_t col;
  logic      write_en;
  logic      sense_en;
  pixel_t    dout;

  modport mst (
    output din,
    output row,
    output col,
    output write_en,
    output sense_en,
    input  dout
  );

  modport slv (
    input  din,
    input  row,
    input  col,
    input  write_en,
    input  sense_en,
    output dout
  );

endinterface

// File: rtl/img_io_rx_controller_raster_counter.sv
// Row-major raster position generator: column advances first, wraps at
// ncols-1 into the next row, and flags the final pixel of the frame.
module img_raster_counter
  import img_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  logic      clear,
  input  logic      step,
  input  img_addr_t nrows,
  input  img_addr_t ncols,
  output img_addr_t row,
  output img_addr_t col,
  output logic      last
);

  img_addr_t row_q, row_d;
  img_addr_t col_q, col_d;
  logic      colWrap;

  assign colWrap = (col_q == (ncols - 8'd1));
  assign last    = colWrap && (row_q == (nrows - 8'd1));
  assign row     = row_q;
  assign col     = col_q;

  // Stepping past the last pixel returns to the origin so the next frame
  // begins at (0,0) without needing a separate clear.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (step) begin
      if (colWrap) begin
        col_d = '0;
        row_d = last ? 8'd0 : (row_q + 8'd1);
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/img_io_rx_controller.sv
// Image receive controller: writes an 8-bit raster stream row-major into the
// image SRAM. Define IO_RX_DONE_EN to add a one-cycle end-of-frame pulse.
module img_io_rx_controller
  import img_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  logic      en,
  input  img_addr_t nrows,
  input  img_addr_t ncols,
  input  pixel_t    din,
  output logic      busy,
  img_sram_intf.mst sram_img
`ifdef IO_RX_DONE_EN
  ,
  output logic      done
`endif
);

  rx_state_t state_q, state_d;
  img_addr_t nrows_q, nrows_d;
  img_addr_t ncols_q, ncols_d;
  pixel_t    din_q, din_d;
  img_addr_t row_q, row_d;
  img_addr_t col_q, col_d;
  logic      writeEn_q, writeEn_d;
  logic      lastPix_q, lastPix_d;

  logic      start;
  logic      sample;
  img_addr_t effRows;
  img_addr_t effCols;
  img_addr_t cntRow;
  img_addr_t cntCol;
  logic      cntLast;

  // Live dimensions matter only on the start edge; afterwards the latched
  // copies govern so input changes mid-frame are harmless.
  assign effRows = (state_q == RX_IDLE) ? nrows : nrows_q;
  assign effCols = (state_q == RX_IDLE) ? ncols : ncols_q;

  assign start  = (state_q == RX_IDLE) && en && (nrows != 8'd0) && (ncols != 8'd0);
  assign sample = start || ((state_q == RX_RECV) && !lastPix_q);

  img_raster_counter u_counter (
    .clk   (clk),
    .rstn  (rstn),
    .clear (!sample),
    .step  (sample),
    .nrows (effRows),
    .ncols (effCols),
    .row   (cntRow),
    .col   (cntCol),
    .last  (cntLast)
  );

  // lastPix_q marks that the final byte is already on the SRAM port, so the
  // following edge commits it and closes the frame.
  always_comb begin
    state_d   = state_q;
    nrows_d   = nrows_q;
    ncols_d   = ncols_q;
    din_d     = din_q;
    row_d     = row_q;
    col_d     = col_q;
    writeEn_d = sample;
    lastPix_d = sample && cntLast;

    case (state_q)
      RX_IDLE: begin
        if (start) begin
          state_d = RX_RECV;
          nrows_d = nrows;
          ncols_d = ncols;
        end
      end
      RX_RECV: begin
        if (lastPix_q) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    if (sample) begin
      din_d = din;
      row_d = cntRow;
      col_d = cntCol;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= RX_IDLE;
      nrows_q   <= '0;
      ncols_q   <= '0;
      din_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      writeEn_q <= 1'b0;
      lastPix_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nrows_q   <= nrows_d;
      ncols_q   <= ncols_d;
      din_q     <= din_d;
      row_q     <= row_d;
      col_q     <= col_d;
      writeEn_q <= writeEn_d;
      lastPix_q <= lastPix_d;
    end
  end

  assign busy              = (state_q == RX_RECV);
  assign sram_img.din      = din_q;
  assign sram_img.row      = row_q;
  assign sram_img.col      = col_q;
  assign sram_img.write_en = writeEn_q;
  assign sram_img.sense_en = ~writeEn_q;

`ifdef IO_RX_DONE_EN
  logic done_q, done_d;

  assign done_d = (state_q == RX_RECV) && lastPix_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`endif

endmodule

// File: tb/tb_img_io_rx_controller.sv
// Directed bench for img_io_rx_controller with a behavioural SRAM and a
// write log; checks the done pulse count when IO_RX_DONE_EN is defined.
module tb_img_io_rx_controller;
  import img_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [7:0] nrows;
  logic [7:0] ncols;
  logic [7:0] din;
  logic       busy;
`ifdef IO_RX_DONE_EN
  logic       done;
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  int doneCount   = 0;

  logic       clearLog = 1'b0;
  logic       clearMem = 1'b0;
  logic [7:0] mem [0:65535];
  logic [7:0] logRow [$];
  logic [7:0] logCol [$];
  logic [7:0] logDin [$];

  img_sram_intf sramIf ();

  img_io_rx_controller dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .nrows    (nrows),
    .ncols    (ncols),
    .din      (din),
    .busy     (busy),
    .sram_img (sramIf)
`ifdef IO_RX_DONE_EN
    ,
    .done     (done)
`endif
  );

  always #5 clk = ~clk;

  assign sramIf.dout = 8'h00;

  // Behavioural SRAM: commits on the rising edge while write_en is high.
  always @(posedge clk) begin
    if (clearMem) begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h5A;
    end
    if (clearLog) begin
      logRow.delete();
      logCol.delete();
      logDin.delete();
    end
    if (sramIf.write_en === 1'b1) begin
      mem[{sramIf.row, sramIf.col}] = sramIf.din;
      logRow.push_back(sramIf.row);
      logCol.push_back(sramIf.col);
      logDin.push_back(sramIf.din);
    end
  end

`ifdef IO_RX_DONE_EN
  always @(posedge clk) begin
    if (done === 1'b1) doneCount++;
  end
`endif

  // Streams byte k = base+k starting at the current negedge; returns at the
  // first negedge with busy low. Dimension inputs are scrambled mid-frame.
  task automatic applyStimulus(input int nr, input int nc, input int base,
                               input int enAgainAt, output int busyCycles);
    int k;
    clearLog   = 1'b1;
    nrows      = nr[7:0];
    ncols      = nc[7:0];
    en         = 1'b1;
    din        = base[7:0];
    busyCycles = 0;
    k          = 1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      clearLog = 1'b0;
      if (busy !== 1'b1) break;
      busyCycles++;
      en    = (cyc == enAgainAt);
      din   = 8'(base + k);
      k++;
      nrows = 8'(nr + 1);
      ncols = 8'(nc + 3);
    end
    en = 1'b0;
  endtask

  task automatic test_reset();
    rstn  = 1'b0;
    en    = 1'b0;
    nrows = 8'd0;
    ncols = 8'd0;
    din   = 8'd0;
    @(posedge clk);
    #1;
    testsRun++;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    testsRun++;
    if (sramIf.write_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_write_en got %b want 0", sramIf.write_en); end
    testsRun++;
    if (sramIf.sense_en !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_sense_en got %b want 1", sramIf.sense_en); end
    testsRun++;
    if (sramIf.row !== 8'd0 || sramIf.col !== 8'd0) begin
      testsFailed++; $display("[TB] FAIL reset_rowcol got %0d,%0d want 0,0", sramIf.row, sramIf.col);
    end
    testsRun++;
    if (sramIf.din !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_din got %h want 00", sramIf.din); end
`ifdef IO_RX_DONE_EN
    testsRun++;
    if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done got %b want 0", done); end
`endif
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame_2x3();
    int bc;
    int bad;
    applyStimulus(2, 3, 8'hA0, -1, bc);
    testsRun++;
    if (bc !== 6) begin testsFailed++; $display("[TB] FAIL f2x3_busy_len got %0d want 6", bc); end
    testsRun++;
    if (logRow.size() !== 6) begin testsFailed++; $display("[TB] FAIL f2x3_write_count got %0d want 6", logRow.size()); end
    bad = -1;
    for (int i = 0; i < 6 && i < logRow.size(); i++) begin
      if (bad < 0 && (logRow[i] !== 8'(i / 3) || logCol[i] !== 8'(i % 3) || logDin[i] !== 8'(8'hA0 + i))) bad = i;
    end
    testsRun++;
    if (bad >= 0) begin
      testsFailed++;
      $display("[TB] FAIL f2x3_order write %0d got (%0d,%0d)=%h want (%0d,%0d)=%h", bad,
               logRow[bad], logCol[bad], logDin[bad], bad / 3, bad % 3, 8'(8'hA0 + bad));
    end
    testsRun++;
    if (sramIf.write_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL f2x3_write_en_after got %b want 0", sramIf.write_en); end
  endtask

  task automatic test_frame_128();
    int bc;
    int badR;
    int badC;
    applyStimulus(128, 128, 0, -1, bc);
    testsRun++;
    if (bc !== 16384) begin testsFailed++; $display("[TB] FAIL f128_busy_len got %0d want 16384", bc); end
    badR = -1;
    badC = -1;
    for (int r = 0; r < 128; r++) begin
      for (int c = 0; c < 128; c++) begin
        if (badR < 0 && mem[r * 256 + c] !== 8'(r * 128 + c)) begin badR = r; badC = c; end
      end
    end
    testsRun++;
    if (badR >= 0) begin
      testsFailed++;
      $display("[TB] FAIL f128_sram (%0d,%0d) got %h want %h", badR, badC, mem[badR * 256 + badC], 8'(badR * 128 + badC));
    end
    testsRun++;
    if (sramIf.write_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL f128_write_en_after got %b want 0", sramIf.write_en); end
    testsRun++;
    if (sramIf.sense_en !== 1'b1) begin testsFailed++; $display("[TB] FAIL f128_sense_en_after got %b want 1", sramIf.sense_en); end
  endtask

  task automatic test_en_while_busy();
    int bc;
    applyStimulus(4, 4, 8'h20, 3, bc);
    testsRun++;
    if (bc !== 16) begin testsFailed++; $display("[TB] FAIL en_busy_len got %0d want 16", bc); end
    testsRun++;
    if (logRow.size() !== 16) begin testsFailed++; $display("[TB] FAIL en_busy_write_count got %0d want 16", logRow.size()); end
  endtask

  task automatic test_reset_midframe();
    int bc;
    int bad;
    logic [7:0] want;
    clearMem = 1'b1;
    @(negedge clk);
    clearMem = 1'b0;
    clearLog = 1'b1;
    nrows    = 8'd4;
    ncols    = 8'd4;
    en       = 1'b1;
    din      = 8'h10;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      clearLog = 1'b0;
      en       = 1'b0;
      din      = 8'(8'h10 + i);
    end
    rstn = 1'b0;
    #1;
    testsRun++;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_busy got %b want 0", busy); end
    testsRun++;
    if (sramIf.write_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_write_en got %b want 0", sramIf.write_en); end
    testsRun++;
    if (sramIf.sense_en !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_mid_sense_en got %b want 1", sramIf.sense_en); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    testsRun++;
    if (logRow.size() !== 4) begin testsFailed++; $display("[TB] FAIL rst_mid_write_count got %0d want 4", logRow.size()); end
    bad = -1;
    for (int k = 0; k < 16; k++) begin
      want = (k < 4) ? 8'(8'h10 + k) : 8'h5A;
      if (bad < 0 && mem[(k / 4) * 256 + (k % 4)] !== want) bad = k;
    end
    testsRun++;
    if (bad >= 0) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_sram pixel %0d got %h want %h", bad, mem[(bad / 4) * 256 + (bad % 4)],
               (bad < 4) ? 8'(8'h10 + bad) : 8'h5A);
    end
    applyStimulus(4, 4, 8'h30, -1, bc);
    testsRun++;
    if (logRow[0] !== 8'd0 || logCol[0] !== 8'd0 || logDin[0] !== 8'h30) begin
      testsFailed++;
      $display("[TB] FAIL rst_restart_first got (%0d,%0d)=%h want (0,0)=30", logRow[0], logCol[0], logDin[0]);
    end
    testsRun++;
    if (logRow.size() !== 16) begin testsFailed++; $display("[TB] FAIL rst_restart_count got %0d want 16", logRow.size()); end
  endtask

  task automatic test_back_to_back();
    int bc1;
    int bc2;
    int bad;
    int d0;
    d0 = doneCount;
    applyStimulus(2, 2, 8'h40, -1, bc1);
    bad = (logRow.size() == 4) ? -1 : 99;
    for (int i = 0; i < 4 && i < logRow.size(); i++) begin
      if (bad < 0 && (logRow[i] !== 8'(i / 2) || logCol[i] !== 8'(i % 2) || logDin[i] !== 8'(8'h40 + i))) bad = i;
    end
    testsRun++;
    if (bc1 !== 4 || bad >= 0) begin
      testsFailed++; $display("[TB] FAIL b2b_frame1 busy %0d bad write %0d want busy 4 bad -1", bc1, bad);
    end
    applyStimulus(2, 2, 8'h50, -1, bc2);
    bad = (logRow.size() == 4) ? -1 : 99;
    for (int i = 0; i < 4 && i < logRow.size(); i++) begin
      if (bad < 0 && (logRow[i] !== 8'(i / 2) || logCol[i] !== 8'(i % 2) || logDin[i] !== 8'(8'h50 + i))) bad = i;
    end
    testsRun++;
    if (bc2 !== 4 || bad >= 0) begin
      testsFailed++; $display("[TB] FAIL b2b_frame2 busy %0d bad write %0d want busy 4 bad -1", bc2, bad);
    end
    testsRun++;
    if (mem[0] !== 8'h50 || mem[257] !== 8'h53) begin
      testsFailed++; $display("[TB] FAIL b2b_sram got %h,%h want 50,53", mem[0], mem[257]);
    end
    @(negedge clk);
`ifdef IO_RX_DONE_EN
    testsRun++;
    if (doneCount - d0 !== 2) begin testsFailed++; $display("[TB] FAIL b2b_done_pulses got %0d want 2", doneCount - d0); end
`endif
  endtask

  task automatic test_zero_dim();
    int busySeen;
    clearLog = 1'b1;
    nrows    = 8'd0;
    ncols    = 8'd5;
    en       = 1'b1;
    busySeen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clearLog = 1'b0;
      if (busy !== 1'b0) busySeen++;
    end
    en = 1'b0;
    @(negedge clk);
    testsRun++;
    if (busySeen !== 0) begin testsFailed++; $display("[TB] FAIL zero_dim_busy got %0d busy cycles want 0", busySeen); end
    testsRun++;
    if (logRow.size() !== 0) begin testsFailed++; $display("[TB] FAIL zero_dim_writes got %0d want 0", logRow.size()); end
  endtask

  task automatic checkOutput();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
  endtask

  initial begin
    test_reset();
    test_frame_2x3();
    test_frame_128();
    test_en_while_busy();
    test_reset_midframe();
    test_back_to_back();
    test_zero_dim();
    checkOutput();
    $finish;
  end

endmodule
